// File: rtl/me_full_search.sv
// me_full_search: full-search integer motion estimation with optional early termination.
// Revision 1.0
`default_nettype none

module me_full_search #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int PIX_W      = 8,
  parameter int SAD_W      = PIX_W + 2*$clog2(MACRO_DIM),
  parameter int MV_W       = $clog2(SEARCH_DIM-MACRO_DIM+1) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          ready,
  input  logic                          early_term_en,
  input  logic                          cur_valid,
  input  logic [MACRO_DIM*PIX_W-1:0]    cur_row,
  output logic                          sr_rd_en,
  output logic [$clog2(SEARCH_DIM)-1:0] sr_y,
  output logic [$clog2(SEARCH_DIM)-1:0] sr_x,
  input  logic [MACRO_DIM*PIX_W-1:0]    sr_row,
  output logic                          valid,
  output logic [SAD_W-1:0]              min_sad,
  output logic [MV_W-1:0]               mv_x,
  output logic [MV_W-1:0]               mv_y
);

  localparam int c_P    = SEARCH_DIM - MACRO_DIM + 1;
  localparam int c_AW   = $clog2(SEARCH_DIM);
  localparam int c_RW   = $clog2(MACRO_DIM);
  localparam int c_HALF = (SEARCH_DIM - MACRO_DIM) / 2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEARCH, S_DONE} state_t;

  state_t                       r_state, w_state_nx;
  logic [MACRO_DIM*PIX_W-1:0]   r_cur [MACRO_DIM];
  logic [c_RW-1:0]              r_lrow;
  logic                         r_et;
  logic                         r_rd_en, r_itag;
  logic [c_AW-1:0]              r_sr_x, r_sr_y, r_icy;
  logic [c_RW-1:0]              r_irow;
  logic                         r_p_valid, r_p_tag;
  logic [c_RW-1:0]              r_p_row;
  logic                         r_ptag, r_have_best, r_last_done;
  logic [c_AW-1:0]              r_pcx, r_pcy, r_bcx, r_bcy;
  logic [SAD_W-1:0]             r_acc, r_best;
  logic                         r_valid, r_ready;
  logic [SAD_W-1:0]             r_min_sad;
  logic [MV_W-1:0]              r_mv_x, r_mv_y;

  logic [MACRO_DIM*PIX_W-1:0]   w_cur_sel;
  logic [SAD_W-1:0]             w_row_sad, w_acc_sum, w_nb;
  logic [c_AW-1:0]              w_nbx, w_nby;
  logic w_load_last, w_take, w_last_row, w_abort, w_upd, w_cand_end, w_last_cand, w_fin;
  logic w_i_next, w_i_last_cand;

  assign w_load_last = (r_state == S_LOAD) && cur_valid && (r_lrow == c_RW'(MACRO_DIM-1));
  assign w_cur_sel   = r_cur[r_p_row];

  always_comb begin
    w_row_sad = '0;
    for (int i = 0; i < MACRO_DIM; i++) begin
      if (w_cur_sel[i*PIX_W +: PIX_W] >= sr_row[i*PIX_W +: PIX_W])
        w_row_sad = w_row_sad + SAD_W'(w_cur_sel[i*PIX_W +: PIX_W] - sr_row[i*PIX_W +: PIX_W]);
      else
        w_row_sad = w_row_sad + SAD_W'(sr_row[i*PIX_W +: PIX_W] - w_cur_sel[i*PIX_W +: PIX_W]);
    end
  end

  // A returning row is only used if its tag matches the candidate being accumulated;
  // the single read issued after an abort carries the old tag and is dropped here.
  assign w_acc_sum   = r_acc + w_row_sad;
  assign w_take      = (r_state == S_SEARCH) && r_p_valid && (r_p_tag == r_ptag);
  assign w_last_row  = (r_p_row == c_RW'(MACRO_DIM-1));
  assign w_abort     = w_take && !w_last_row && r_et && r_have_best && (w_acc_sum >= r_best);
  assign w_upd       = w_take && w_last_row && (!r_have_best || (w_acc_sum < r_best));
  assign w_cand_end  = w_take && (w_last_row || w_abort);
  assign w_last_cand = (r_pcx == c_AW'(c_P-1)) && (r_pcy == c_AW'(c_P-1));
  assign w_fin       = (r_state == S_SEARCH) && !r_rd_en &&
                       (r_last_done || (w_cand_end && w_last_cand));
  assign w_nb        = w_upd ? w_acc_sum : r_best;
  assign w_nbx       = w_upd ? r_pcx : r_bcx;
  assign w_nby       = w_upd ? r_pcy : r_bcy;

  assign w_i_next      = r_rd_en && ((r_irow == c_RW'(MACRO_DIM-1)) || w_abort);
  assign w_i_last_cand = (r_sr_x == c_AW'(c_P-1)) && (r_icy == c_AW'(c_P-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (start)       w_state_nx = S_LOAD;
      S_LOAD:   if (w_load_last) w_state_nx = S_SEARCH;
      S_SEARCH: if (w_fin)       w_state_nx = S_DONE;
      S_DONE:                    w_state_nx = S_IDLE;
      default:                   w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && cur_valid) r_cur[r_lrow] <= cur_row;
  end

  // Read issue: sr_x doubles as the candidate column counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en <= 1'b0; r_sr_x <= '0; r_sr_y <= '0; r_icy <= '0; r_irow <= '0; r_itag <= 1'b0;
      r_p_valid <= 1'b0; r_p_row <= '0; r_p_tag <= 1'b0;
    end else begin
      r_p_valid <= r_rd_en;
      r_p_row   <= r_irow;
      r_p_tag   <= r_itag;
      if (w_load_last) begin
        r_rd_en <= 1'b1; r_sr_x <= '0; r_sr_y <= '0; r_icy <= '0; r_irow <= '0; r_itag <= 1'b0;
      end else if (w_i_next) begin
        r_irow <= '0;
        r_itag <= ~r_itag;
        if (w_i_last_cand) begin
          r_rd_en <= 1'b0;
        end else if (r_sr_x == c_AW'(c_P-1)) begin
          r_sr_x <= '0;
          r_icy  <= r_icy + 1'b1;
          r_sr_y <= r_icy + 1'b1;
        end else begin
          r_sr_x <= r_sr_x + 1'b1;
          r_sr_y <= r_icy;
        end
      end else if (r_rd_en) begin
        r_irow <= r_irow + 1'b1;
        r_sr_y <= r_sr_y + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_et <= 1'b0; r_lrow <= '0; r_acc <= '0; r_best <= '0; r_have_best <= 1'b0;
      r_last_done <= 1'b0; r_ptag <= 1'b0; r_pcx <= '0; r_pcy <= '0; r_bcx <= '0; r_bcy <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_et <= early_term_en; r_lrow <= '0; r_acc <= '0; r_have_best <= 1'b0;
      r_last_done <= 1'b0; r_ptag <= 1'b0; r_pcx <= '0; r_pcy <= '0;
    end else begin
      if (r_state == S_LOAD && cur_valid) r_lrow <= r_lrow + 1'b1;
      if (w_take) r_acc <= (w_last_row || w_abort) ? '0 : w_acc_sum;
      if (w_upd) begin
        r_best <= w_acc_sum; r_bcx <= r_pcx; r_bcy <= r_pcy; r_have_best <= 1'b1;
      end
      if (w_cand_end) begin
        r_ptag <= ~r_ptag;
        if (w_last_cand) r_last_done <= 1'b1;
        if (r_pcx == c_AW'(c_P-1)) begin
          r_pcx <= '0;
          r_pcy <= r_pcy + 1'b1;
        end else begin
          r_pcx <= r_pcx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0; r_ready <= 1'b1; r_min_sad <= '0; r_mv_x <= '0; r_mv_y <= '0;
    end else begin
      r_valid <= w_fin;
      r_ready <= (w_state_nx == S_IDLE);
      if (w_fin) begin
        r_min_sad <= w_nb;
        r_mv_x    <= MV_W'(w_nbx) - MV_W'(c_HALF);
        r_mv_y    <= MV_W'(w_nby) - MV_W'(c_HALF);
      end
    end
  end

  assign ready    = r_ready;
  assign valid    = r_valid;
  assign min_sad  = r_min_sad;
  assign mv_x     = r_mv_x;
  assign mv_y     = r_mv_y;
  assign sr_rd_en = r_rd_en;
  assign sr_x     = r_sr_x;
  assign sr_y     = r_sr_y;

endmodule

`default_nettype wire

// File: tb/tb_me_full_search.sv
// tb_me_full_search: table-driven scoreboard bench for me_full_search (M=4, S=12).
`default_nettype none

module tb_me_full_search;

  localparam int M = 4;
  localparam int S = 12;
  localparam int P = S - M + 1;
  localparam int PW = 8;
  localparam int SW = 12;
  localparam int MW = 5;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, start, ready, early_term_en, cur_valid, sr_rd_en, valid;
  logic [M*PW-1:0] cur_row, sr_row;
  logic [AW-1:0]   sr_x, sr_y;
  logic [SW-1:0]   min_sad;
  logic [MW-1:0]   mv_x, mv_y;

  me_full_search #(.MACRO_DIM(M), .SEARCH_DIM(S), .PIX_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .early_term_en(early_term_en),
    .cur_valid(cur_valid), .cur_row(cur_row), .sr_rd_en(sr_rd_en), .sr_y(sr_y), .sr_x(sr_x),
    .sr_row(sr_row), .valid(valid), .min_sad(min_sad), .mv_x(mv_x), .mv_y(mv_y)
  );

  logic [7:0] win [S][S];
  logic [7:0] cur [M][M];

  // Search RAM model: one-cycle read latency.
  always @(posedge clk) begin
    if (sr_rd_en)
      for (int i = 0; i < M; i++) sr_row[i*PW +: PW] <= win[int'(sr_y)][int'(sr_x) + i];
  end

  typedef struct {int sad; int mvx; int mvy; int reads; bit chk_lat;} exp_t;
  typedef struct {int pat; int ex; int ey; bit et; bit gaps; bit pulse; bit cst;
                  int esad; int emx; int emy;} vec_t;

  exp_t sb[$];
  int checks = 0, errors = 0;
  int cyc = 0, first_rd = -1, rd_cnt = 0;
  bit prev_valid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (sr_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        rd_cnt++;
      end
      if (prev_valid) begin
        check("ready_after_valid", int'(ready), 1);
        check("valid_one_cycle", int'(valid), 0);
      end
      if (valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("min_sad", int'(min_sad), e.sad);
          check("mv_x", int'($signed(mv_x)), e.mvx);
          check("mv_y", int'($signed(mv_y)), e.mvy);
          check("read_count", rd_cnt, e.reads);
          if (e.chk_lat) check("latency", cyc - first_rd, M*P*P + 1);
        end
      end
      prev_valid = valid;
    end
  end

  function automatic int row_sad(input int cx, input int cy, input int r);
    int s = 0;
    for (int i = 0; i < M; i++) begin
      int a = int'(cur[r][i]);
      int b = int'(win[cy+r][cx+i]);
      s += (a > b) ? a - b : b - a;
    end
    return s;
  endfunction

  // Reference: raster-order search, strict-less update, early-termination read accounting.
  task automatic model(input bit et, output int bs, output int bx, output int by, output int reads);
    bs = 0; bx = 0; by = 0; reads = 0;
    for (int cy = 0; cy < P; cy++) begin
      for (int cx = 0; cx < P; cx++) begin
        int acc = 0;
        bit ab = 1'b0;
        bit first = (cx == 0 && cy == 0);
        for (int r = 0; r < M; r++) begin
          acc += row_sad(cx, cy, r);
          if (et && !first && r < M-1 && acc >= bs) begin
            reads += r + 2;
            ab = 1'b1;
            break;
          end
        end
        if (!ab) begin
          reads += M;
          if (first || acc < bs) begin bs = acc; bx = cx; by = cy; end
        end
      end
    end
    bx -= (S-M)/2;
    by -= (S-M)/2;
  endtask

  task automatic fill(input vec_t v);
    for (int y = 0; y < S; y++)
      for (int x = 0; x < S; x++) win[y][x] = (v.pat == 1) ? 8'd13 : 8'($urandom);
    for (int r = 0; r < M; r++)
      for (int i = 0; i < M; i++)
        cur[r][i] = (v.pat == 1) ? 8'd10 : (v.pat == 0) ? win[v.ey+r][v.ex+i] : 8'($urandom);
  endtask

  task automatic drive(input bit et, input bit gaps);
    int t = 0;
    while (!ready && t < 1000) begin @(posedge clk); #1; t++; end
    if (!ready) check("ready_timeout", 0, 1);
    first_rd = -1;
    rd_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; early_term_en = et;
    @(posedge clk); #1;
    start = 1'b0; early_term_en = 1'b0;
    for (int r = 0; r < M; r++) begin
      cur_valid = 1'b1;
      for (int i = 0; i < M; i++) cur_row[i*PW +: PW] = cur[r][i];
      @(posedge clk); #1;
      cur_valid = 1'b0;
      if (gaps && r < M-1) repeat (3) begin @(posedge clk); #1; end
    end
  endtask

  task automatic run(input vec_t v);
    exp_t e;
    int bs, bx, by, rd, t;
    fill(v);
    model(v.et, bs, bx, by, rd);
    e.sad = v.cst ? v.esad : bs;
    e.mvx = v.cst ? v.emx : bx;
    e.mvy = v.cst ? v.emy : by;
    e.reads = rd;
    e.chk_lat = !v.et;
    sb.push_back(e);
    drive(v.et, v.gaps);
    if (v.pulse) begin
      repeat (40) @(posedge clk);
      #1;
      check("ready_low_in_search", int'(ready), 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    t = 0;
    while (sb.size() != 0 && t < 3000) begin @(posedge clk); t++; end
    if (sb.size() != 0) begin
      check("result_timeout", 0, 1);
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    if (v.et && v.pat == 0) check("et_fewer_reads", int'(rd_cnt < M*P*P), 1);
    if (v.pulse) check("no_restart_after_pulse", int'(ready), 1);
  endtask

  vec_t tbl[8];

  initial begin
    vec_t vx;
    int t;
    tbl[0] = '{0, 6, 2, 1'b0, 1'b0, 1'b0, 1'b1, 0, 2, -2};
    tbl[1] = '{1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 48, -4, -4};
    tbl[2] = '{0, 6, 2, 1'b1, 1'b0, 1'b0, 1'b1, 0, 2, -2};
    tbl[3] = '{0, 6, 2, 1'b0, 1'b1, 1'b1, 1'b1, 0, 2, -2};
    tbl[4] = '{0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 0, -4, -4};
    tbl[5] = '{0, 8, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 4, 4};
    tbl[6] = '{2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    tbl[7] = '{2, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0};

    rst_n = 1'b0; start = 1'b1; early_term_en = 1'b0; cur_valid = 1'b0; cur_row = '0;
    #12;
    check("rst_ready", int'(ready), 1);
    check("rst_valid", int'(valid), 0);
    check("rst_min_sad", int'(min_sad), 0);
    check("rst_mv_x", int'(mv_x), 0);
    check("rst_mv_y", int'(mv_y), 0);
    check("rst_rd_en", int'(sr_rd_en), 0);
    check("rst_sr_x", int'(sr_x), 0);
    check("rst_sr_y", int'(sr_y), 0);
    #1 start = 1'b0;
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("start_in_reset_ignored", int'(ready), 1);
    check("no_read_after_reset", int'(sr_rd_en), 0);

    for (int k = 0; k < 8; k++) run(tbl[k]);

    // Reset in the middle of SEARCH.
    vx = tbl[0];
    fill(vx);
    drive(1'b0, 1'b0);
    t = 0;
    while (rd_cnt < 100 && t < 2000) begin @(negedge clk); t++; end
    check("reached_read_100", int'(rd_cnt >= 100), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rd_en", int'(sr_rd_en), 0);
    check("midrst_ready", int'(ready), 1);
    check("midrst_valid", int'(valid), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    check("idle_after_midrst", int'(ready), 1);
    run(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d checks, expected completion", checks);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
